// File: rtl/conv3x3_frame_ctrl.sv
// Frame sequencer for the 3x3 pipelined convolver: builds raster windows from two
// line buffers, owns the kernel taps, counts results and reports frame completion.
module conv3x3_frame_ctrl #(
  parameter int BITW  = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [BITW-1:0]                   s_data,
  input  logic                              k_wr_en,
  input  logic [3:0]                        k_wr_addr,
  input  logic [7:0]                        k_wr_data,
  output logic [9*BITW-1:0]                 win_flat,
  output logic [71:0]                       kern_flat,
  output logic                              win_valid,
  input  logic                              conv_valid,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(IMG_W*IMG_H):0]      out_count,
  output logic                              err
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int CNT_W = $clog2(IMG_W*IMG_H) + 1;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] EXP_CNT  = CNT_W'((IMG_W - 2) * (IMG_H - 2));
  localparam logic [71:0]      KERN_ID  = {32'h0, 8'h01, 32'h0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [ROW_W-1:0]       r_row;
  logic [COL_W-1:0]       r_col;
  logic [BITW-1:0]        r_lb0 [IMG_W];
  logic [BITW-1:0]        r_lb1 [IMG_W];
  logic [8:0][BITW-1:0]   r_win;
  logic [8:0][7:0]        r_kern;
  logic                   r_sReady;
  logic                   r_winValid;
  logic                   r_busy;
  logic                   r_done;
  logic [CNT_W-1:0]       r_outCount;
  logic                   r_err;

  logic w_accept;
  logic w_lastCol;
  logic w_emit;
  logic w_kernWrOk;
  logic w_counting;

  assign w_accept   = s_valid & r_sReady;
  assign w_lastCol  = (r_col == LAST_COL);
  assign w_emit     = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
  assign w_kernWrOk = k_wr_en && (k_wr_addr <= 4'd8);
  assign w_counting = (r_state == S_FILL) || (r_state == S_RUN) || (r_state == S_DRAIN);

  // lb0 holds the previous row, lb1 the row before it; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= s_data;
    end
  end

  // Window index is 3*row+col, so entries 2/5/8 form the newest (right) column
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        r_win[3*i]   <= r_win[3*i+1];
        r_win[3*i+1] <= r_win[3*i+2];
      end
      r_win[2] <= r_lb1[r_col];
      r_win[5] <= r_lb0[r_col];
      r_win[8] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_sReady   <= 1'b0;
      r_winValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_outCount <= '0;
      r_err      <= 1'b0;
      r_kern     <= KERN_ID;
    end else begin
      r_winValid <= w_emit;
      r_done     <= 1'b0;

      if (w_accept) begin
        if (w_lastCol) begin
          r_col <= '0;
          r_row <= r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_kernWrOk) r_kern[k_wr_addr] <= k_wr_data;
          if (start) begin
            r_state    <= S_FILL;
            r_sReady   <= 1'b1;
            r_busy     <= 1'b1;
            r_outCount <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_err      <= 1'b0;
          end
        end
        S_FILL: begin
          if (w_accept && w_lastCol && (r_row == ROW_W'(1))) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_accept && w_lastCol && (r_row == LAST_ROW)) begin
            r_state  <= S_DRAIN;
            r_sReady <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (r_outCount == EXP_CNT) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Protocol errors are evaluated last so they win over the start-time clear
      if (k_wr_en && (r_state != S_IDLE)) r_err <= 1'b1;
      if (conv_valid) begin
        if (!w_counting) begin
          r_err <= 1'b1;
        end else if (r_outCount == EXP_CNT) begin
          r_err <= 1'b1;
        end else begin
          r_outCount <= r_outCount + CNT_W'(1);
        end
      end
    end
  end

  assign s_ready   = r_sReady;
  assign win_flat  = r_win;
  assign kern_flat = r_kern;
  assign win_valid = r_winValid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_count = r_outCount;
  assign err       = r_err;

endmodule

// File: tb/tb_conv3x3_frame_ctrl.sv
// Bench for conv3x3_frame_ctrl on a 4x4 frame: a transaction-level model of the
// frame/kernel/error rules plus a fixed-latency stand-in for the convolver.
module tb_conv3x3_frame_ctrl;

  localparam int BITW = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int N    = W * H;
  localparam int EXPW = (W - 2) * (H - 2);
  localparam logic [71:0] KID   = 72'h00_00_00_00_01_00_00_00_00;
  localparam logic [71:0] KONES = 72'h01_01_01_01_01_01_01_01_01;

  typedef enum int {P_IDLE, P_ACTIVE, P_DONEC} phase_t;

  typedef struct {
    bit          wrEn;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [71:0] expKern;
  } kvec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               s_valid;
  logic               s_ready;
  logic [BITW-1:0]    s_data;
  logic               k_wr_en;
  logic [3:0]         k_wr_addr;
  logic [7:0]         k_wr_data;
  logic [9*BITW-1:0]  win_flat;
  logic [71:0]        kern_flat;
  logic               win_valid;
  logic               conv_valid;
  logic               busy;
  logic               done;
  logic [4:0]         out_count;
  logic               err;

  conv3x3_frame_ctrl #(.BITW(BITW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr), .k_wr_data(k_wr_data),
    .win_flat(win_flat), .kern_flat(kern_flat), .win_valid(win_valid),
    .conv_valid(conv_valid), .busy(busy), .done(done),
    .out_count(out_count), .err(err)
  );

  always #5 clk = ~clk;

  // Convolver stand-in: every window yields one result three cycles later
  logic [2:0] convPipe;
  logic       forceConv;
  always @(posedge clk) begin
    if (rst) convPipe <= '0;
    else     convPipe <= {convPipe[1:0], win_valid};
  end
  assign conv_valid = convPipe[2] | forceConv;

  int          total = 0;
  int          bad = 0;
  phase_t      phase;
  int          accCnt;
  int          outM;
  bit          errM;
  logic [71:0] kernM;
  logic [7:0]  pix [N];
  int          doneCnt;
  bit          sawDone;
  logic [7:0]  centreQ [$];
  kvec_t       kTab [7];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare
  task automatic tick();
    bit                acc, cv, emit;
    int                r, c;
    phase_t            prePhase;
    logic [9*BITW-1:0] expWin;
    acc  = (s_valid === 1'b1) && (s_ready === 1'b1) && (rst !== 1'b1);
    cv   = (forceConv === 1'b1) || (convPipe[2] === 1'b1);
    r    = accCnt / W;
    c    = accCnt % W;
    emit = acc && (r >= 2) && (c >= 2);
    expWin = '0;
    if (emit)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          expWin[BITW*(3*i+j) +: BITW] = pix[(r-2+i)*W + (c-2+j)];
    prePhase = phase;
    if (rst === 1'b1) begin
      phase = P_IDLE; errM = 1'b0; outM = 0; accCnt = 0; kernM = KID;
    end else begin
      case (phase)
        P_IDLE: begin
          if (k_wr_en && k_wr_addr <= 4'd8) kernM[8*k_wr_addr +: 8] = k_wr_data;
          if (start) begin phase = P_ACTIVE; errM = 1'b0; outM = 0; accCnt = 0; end
          if (cv) errM = 1'b1;
        end
        P_ACTIVE: begin
          if (k_wr_en) errM = 1'b1;
          if (cv) begin
            if (outM == EXPW) errM = 1'b1;
            else outM++;
          end
          if (acc) accCnt++;
        end
        default: begin
          if (k_wr_en) errM = 1'b1;
          if (cv) errM = 1'b1;
          phase = P_IDLE;
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (emit || win_valid !== 1'b0) checkOutput("win_valid", win_valid, emit);
    if (emit) begin
      checkOutput("win_flat", win_flat, expWin);
      centreQ.push_back(win_flat[4*BITW +: BITW]);
    end
    if (prePhase == P_DONEC) checkOutput("done_width", done, 1'b0);
    if (done === 1'b1) begin
      doneCnt++;
      sawDone = 1'b1;
      checkOutput("done_cond", {accCnt == N, outM == EXPW, phase == P_ACTIVE}, 3'b111);
      phase = P_DONEC;
    end
    checkOutput("s_ready", s_ready, (phase == P_ACTIVE) && (accCnt < N));
    checkOutput("busy", busy, phase == P_ACTIVE);
    checkOutput("err", err, errM);
    checkOutput("out_count", out_count, outM);
    checkOutput("kern_flat", kern_flat, kernM);
  endtask

  // Feeds pixels until stopAfter have been accepted; gapMode 0=steady, 1=toggle, 2=random
  task automatic applyStimulus(input int gapMode, input int injectAt, input int stopAfter);
    int guard = 0;
    bit injected = 1'b0;
    while (accCnt < stopAfter && guard < 2000) begin
      case (gapMode)
        0:       s_valid = 1'b1;
        1:       s_valid = (guard % 2 == 0);
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      s_data = pix[accCnt];
      if (injectAt >= 0 && accCnt == injectAt && !injected) begin
        start = 1'b1; k_wr_en = 1'b1; k_wr_addr = 4'd4; k_wr_data = 8'hFF;
        injected = 1'b1;
      end
      tick();
      start = 1'b0;
      k_wr_en = 1'b0;
      guard++;
    end
    s_valid = 1'b0;
    if (accCnt < stopAfter) failNow("accept_timeout");
  endtask

  task automatic startFrame();
    doneCnt = 0;
    sawDone = 1'b0;
    centreQ.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone();
    int g = 0;
    while (!sawDone && g < 200) begin
      tick();
      g++;
    end
    if (!sawDone) failNow("done_timeout");
    tick();
    checkOutput("done_count", doneCnt, 1);
  endtask

  task automatic checkCentres();
    int expC [4] = '{17, 18, 33, 34};
    checkOutput("window_count", centreQ.size(), 4);
    for (int i = 0; i < 4 && i < centreQ.size(); i++)
      checkOutput("window_centre", centreQ[i], expC[i]);
  endtask

  task automatic fillRamp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix[r*W + c] = 8'(16*r + c);
  endtask

  task automatic fillRandom();
    for (int i = 0; i < N; i++) pix[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    k_wr_en = 1'b0; k_wr_addr = '0; k_wr_data = '0; forceConv = 1'b0;
    phase = P_IDLE; accCnt = 0; outM = 0; errM = 1'b0; kernM = KID;
    doneCnt = 0; sawDone = 1'b0;
    for (int i = 0; i < N; i++) pix[i] = '0;

    kTab[0] = '{1'b1, 4'd0,  8'h11, 72'h00_00_00_00_01_00_00_00_11};
    kTab[1] = '{1'b1, 4'd8,  8'h80, 72'h80_00_00_00_01_00_00_00_11};
    kTab[2] = '{1'b1, 4'd9,  8'hFF, 72'h80_00_00_00_01_00_00_00_11};
    kTab[3] = '{1'b1, 4'd15, 8'h77, 72'h80_00_00_00_01_00_00_00_11};
    kTab[4] = '{1'b1, 4'd4,  8'hFE, 72'h80_00_00_00_FE_00_00_00_11};
    kTab[5] = '{1'b0, 4'd3,  8'h55, 72'h80_00_00_00_FE_00_00_00_11};
    kTab[6] = '{1'b1, 4'd3,  8'hA5, 72'h80_00_00_00_FE_A5_00_00_11};

    tick();
    tick();
    rst = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_s_ready", s_ready, 1'b0);
    checkOutput("rst_win_valid", win_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_out_count", out_count, 5'd0);
    checkOutput("rst_win_flat", win_flat, 72'h0);
    checkOutput("rst_kern", kern_flat, KID);

    $display("[TB] kernel write table");
    for (int i = 0; i < 7; i++) begin
      k_wr_en = kTab[i].wrEn; k_wr_addr = kTab[i].addr; k_wr_data = kTab[i].data;
      tick();
      k_wr_en = 1'b0;
      checkOutput("ktab", kern_flat, kTab[i].expKern);
    end
    pulseReset();
    checkOutput("rst_restores_kern", kern_flat, KID);

    $display("[TB] ramp frame, identity kernel, steady valid");
    fillRamp();
    startFrame();
    applyStimulus(0, -1, N);
    waitDone();
    checkCentres();
    checkOutput("f1_out_count", out_count, 5'd4);
    checkOutput("f1_err", err, 1'b0);

    $display("[TB] all-ones kernel, saturated frame");
    for (int i = 0; i < 9; i++) begin
      k_wr_en = 1'b1; k_wr_addr = 4'(i); k_wr_data = 8'd1;
      tick();
    end
    k_wr_en = 1'b0;
    checkOutput("ones_kern", kern_flat, KONES);
    for (int i = 0; i < N; i++) pix[i] = 8'hFF;
    startFrame();
    applyStimulus(0, -1, N);
    waitDone();
    checkOutput("f2_out_count", out_count, 5'd4);
    checkOutput("f2_kern_held", kern_flat, KONES);

    $display("[TB] ramp frame, toggling valid");
    fillRamp();
    startFrame();
    applyStimulus(1, -1, N);
    waitDone();
    checkCentres();

    $display("[TB] start and kernel write during RUN");
    fillRamp();
    startFrame();
    applyStimulus(0, 10, N);
    waitDone();
    checkCentres();
    checkOutput("run_write_err", err, 1'b1);
    checkOutput("run_write_kern", kern_flat, KONES);

    $display("[TB] reset mid-frame");
    startFrame();
    checkOutput("start_clears_err", err, 1'b0);
    applyStimulus(0, -1, 6);
    pulseReset();
    checkOutput("midrst_s_ready", s_ready, 1'b0);
    checkOutput("midrst_out_count", out_count, 5'd0);
    checkOutput("midrst_err", err, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    fillRandom();
    startFrame();
    applyStimulus(2, -1, N);
    waitDone();
    checkOutput("post_rst_count", out_count, 5'd4);

    $display("[TB] result while idle");
    pulseReset();
    forceConv = 1'b1;
    tick();
    forceConv = 1'b0;
    checkOutput("idle_conv_err", err, 1'b1);
    checkOutput("idle_conv_count", out_count, 5'd0);
    fillRandom();
    startFrame();
    checkOutput("start_clears_idle_err", err, 1'b0);
    applyStimulus(2, -1, N);
    waitDone();

    $display("[TB] random frames");
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        k_wr_en = 1'b1;
        k_wr_addr = 4'($urandom_range(0, 15));
        k_wr_data = 8'($urandom_range(0, 255));
        tick();
      end
      k_wr_en = 1'b0;
      fillRandom();
      startFrame();
      applyStimulus(2, -1, N);
      waitDone();
      checkOutput("rand_count", out_count, 5'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv3x3_frame_ctrl.md
Name: conv3x3_frame_ctrl

Overview:
Frame sequencer for the 3x3 pipelined convolver.
- Accepts a raster-order pixel stream with a valid/ready handshake.
- Builds the 3x3 window from two line buffers plus a window shift register.
- Drives the convolver's window taps, kernel taps and in_valid.
- Counts convolver results, flags protocol errors, and pulses done when a frame has fully drained.

Parameters:
BITW, 8, pixel width in bits
IMG_W, 64, frame width in pixels (>=3)
IMG_H, 64, frame height in pixels (>=3)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high (fixed)
start  in  1  1-cycle pulse that begins a frame; honoured only in IDLE
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel ready
s_data  in  BITW  input pixel, raster order
k_wr_en  in  1  kernel coefficient write strobe
k_wr_addr  in  4  coefficient index 0..8, row-major (0=k00 .. 8=k22)
k_wr_data  in  8  signed coefficient
win_flat  out  9*BITW  window taps; [BITW-1:0]=u00 ... top slice=u22, row-major
kern_flat  out  72  kernel taps; [7:0]=k00 ... [71:64]=k22
win_valid  out  1  in_valid to the convolver
conv_valid  in  1  out_valid from the convolver
busy  out  1  high in FILL, RUN and DRAIN
done  out  1  1-cycle pulse at end of frame
out_count  out  $clog2(IMG_W*IMG_H)+1  results received in the current frame
err  out  1  sticky protocol-error flag; cleared by rst or an accepted start

Behaviour:
Reset values:
- State IDLE; s_ready, win_valid, busy, done, err = 0; out_count = 0; win_flat = 0.
- Kernel = identity: k11 = 1, all other coefficients 0.
- Row/column counters = 0. Line buffer contents need not be reset.
- The convolver shares rst, so in-flight results are discarded on reset.

States (one-hot or binary):
- IDLE: s_ready = 0. start -> FILL; clears out_count, row, col and err.
- FILL: rows 0-1. s_ready = 1. No windows are emitted. Moves to RUN after the pixel at (1, IMG_W-1) is accepted.
- RUN: s_ready = 1. Moves to DRAIN after pixel (IMG_H-1, IMG_W-1) is accepted.
- DRAIN: s_ready = 0. Waits until out_count == (IMG_W-2)*(IMG_H-2), then goes to DONE.
- DONE: done = 1 for exactly 1 cycle, then IDLE. busy = 0 in DONE.

Pixel accept (s_valid & s_ready):
- col increments; at IMG_W-1 it wraps to 0 and row increments.
- Line buffers shift in the pixel at column col.
- Window columns shift left; the new right column = {line_buf1[col], line_buf0[col], s_data} (top to bottom).
- No accept = no state change in the datapath; s_valid gaps are legal.

Window emission:
- If the accepted pixel has row>=2 and col>=2, win_valid = 1 on the next cycle, with win_flat registered in the same cycle.
- The window is centred at (row-1, col-1): u22 = that pixel, u00 = pixel (row-2, col-2).
- Otherwise win_valid = 0. Stale columns at row start are never emitted because of the col>=2 gate.
- Accept-to-win_valid latency = 1 cycle.
- Windows per frame = (IMG_W-2)*(IMG_H-2), in raster order of the window centre.

Kernel writes:
- Applied on the clock edge in IDLE only. k_wr_addr > 8 is ignored.
- Writes in any other state are ignored and set err.
- start and k_wr_en in the same IDLE cycle: the write takes effect and the frame uses the new value.
- kern_flat is constant from FILL through DONE.

Result counting:
- conv_valid increments out_count in FILL, RUN and DRAIN.
- conv_valid in IDLE or DONE sets err; out_count is unchanged.
- conv_valid while out_count is already at the expected value sets err; out_count saturates.

Other rules:
- start outside IDLE is ignored and does not set err.
- Reset mid-frame returns every register to its reset value within 1 cycle; the next frame requires a new start.

Test Plan:
- IMG_W=IMG_H=4, identity kernel, p(r,c)=16r+c, s_valid held high -> win_valid pulses 4 times, centres 17, 18, 33, 34; out_count reaches 4; done pulses once; err=0.
- Load k00..k22 = 1 (addresses 0..8) in IDLE, then an all-255 4x4 frame -> kern_flat = 72'h010101010101010101; 4 results, each clamped to 255.
- Same frame as the first test with s_valid toggling 1-0-1-0 -> identical window sequence, each win_valid exactly 1 cycle after its accepting edge, s_ready low in DRAIN.
- During RUN: start pulse plus k_wr_en (addr 4, data 8'hFF) -> frame is unaffected, kernel is unchanged, err=1 after the write.
- Assert rst after 6 accepted pixels -> next cycle state IDLE, s_ready=0, out_count=0, err=0; a new start and frame completes normally.
- Force conv_valid high for 1 cycle in IDLE -> err=1, out_count stays 0; the next accepted start clears err.
